// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Frame geometry
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CHK_WIDTH  = 8;

  // True in the states that take bytes from the stream
  function automatic logic isReceiving(input state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs big-endian stream bytes into 32-bit instruction words.
// o_word_complete pulses the cycle after the fourth byte of a word,
// while o_word still holds the fully assembled word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_strobe,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_lane,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic        r_word_complete;

  // Shift each accepted byte in MSB-first and flag the end of a word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane          <= 2'd0;
      r_word          <= 32'd0;
      r_word_complete <= 1'b0;
    end else begin
      r_word_complete <= 1'b0;
      if (i_clear) begin
        r_lane <= 2'd0;
        r_word <= 32'd0;
      end else if (i_byte_strobe) begin
        r_word          <= {r_word[23:0], i_byte};
        r_lane          <= r_lane + 2'd1;
        r_word_complete <= (r_lane == 2'(WORD_BYTES - 1));
      end
    end
  end

  assign o_lane          = r_lane;
  assign o_word          = r_word;
  assign o_word_complete = r_word_complete;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream (word-count header,
// big-endian words, checksum) and writes it into the instruction RAM
// while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [31:0]           o_wr_data,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int NW = HDR_BYTES * 8;
  localparam logic [NW:0] CAPACITY = (NW + 1)'(1) << ADDR_WIDTH;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_word_count;
  logic [CHK_WIDTH-1:0] r_checksum;
  logic [TW-1:0]        r_timeout;
  logic [NW-1:0]        r_n_words;

  logic          w_receiving;
  logic          w_accept;
  logic          w_start_load;
  logic          w_data_accept;
  logic          w_last_byte;
  logic          w_last_word;
  logic          w_timeout;
  logic [NW-1:0] w_hdr_n;
  logic          w_oversize;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic          w_word_complete;

  assign w_receiving   = isReceiving(r_state);
  assign w_accept      = i_byte_valid && w_receiving;
  assign w_start_load  = i_start && ((r_state == IDLE) || (r_state == ERR));
  assign w_data_accept = w_accept && (r_state == DATA);
  assign w_last_byte   = w_data_accept && (w_lane == 2'(WORD_BYTES - 1));
  assign w_last_word   = ((NW + 1)'(r_word_count) + (NW + 1)'(1)) == {1'b0, r_n_words};
  assign w_timeout     = w_receiving && !w_accept && (r_timeout == TW'(TIMEOUT_CYCLES - 1));
  assign w_hdr_n       = {r_n_words[NW-9:0], i_byte_data};
  assign w_oversize    = {1'b0, w_hdr_n} > CAPACITY;

  imem_word_packer u_packer (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_clear         (w_start_load),
    .i_byte_strobe   (w_data_accept),
    .i_byte          (i_byte_data),
    .o_lane          (w_lane),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic; DATA leaves on the last payload byte so the checksum
  // byte can follow immediately while the final write is still in flight
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_load) w_next_state = HDR_HI;
      HDR_HI:  if (w_accept) w_next_state = HDR_LO;
      HDR_LO: begin
        if (w_accept) begin
          if (w_oversize)            w_next_state = ERR;
          else if (w_hdr_n == '0)    w_next_state = CHECK;
          else                       w_next_state = DATA;
        end
      end
      DATA:    if (w_last_byte && w_last_word) w_next_state = CHECK;
      CHECK: begin
        if (w_accept) begin
          if (i_byte_data == r_checksum) w_next_state = DONE;
          else                           w_next_state = ERR;
        end
      end
      DONE:    w_next_state = IDLE;
      ERR:     if (w_start_load) w_next_state = HDR_HI;
      default: w_next_state = IDLE;
    endcase
    if (w_timeout) w_next_state = ERR;
  end

  // Header, checksum, word counter and inactivity timer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_count <= '0;
      r_checksum   <= '0;
      r_timeout    <= '0;
      r_n_words    <= '0;
    end else if (w_start_load) begin
      r_word_count <= '0;
      r_checksum   <= '0;
      r_timeout    <= '0;
      r_n_words    <= '0;
    end else begin
      if (w_word_complete) r_word_count <= r_word_count + CW'(1);
      if (w_data_accept)   r_checksum   <= r_checksum + i_byte_data;
      if (w_accept && ((r_state == HDR_HI) || (r_state == HDR_LO)))
        r_n_words <= w_hdr_n;
      if (!w_receiving || w_accept) r_timeout <= '0;
      else                          r_timeout <= r_timeout + TW'(1);
    end
  end

  assign o_byte_ready = w_receiving;
  assign o_cpu_hold   = w_receiving || (r_state == ERR);
  assign o_done       = (r_state == DONE);
  assign o_error      = (r_state == ERR);
  assign o_wr_en      = w_word_complete;
  assign o_wr_addr    = r_word_count[ADDR_WIDTH-1:0];
  assign o_wr_data    = w_word;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a 16-cycle inactivity timeout.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk;
  logic          rstN;
  logic          start;
  logic          byteValid;
  logic [7:0]    byteData;
  logic          byteReady;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [31:0]   wrData;
  logic          cpuHold;
  logic          done;
  logic          error;
  logic [AW:0]   wordCount;

  int assertCount = 0;
  int failCount   = 0;

  int          wrCnt = 0;
  int          doneCnt = 0;
  logic [7:0]  wrAddrLog [0:7];
  logic [31:0] wrDataLog [0:7];
  logic [7:0]  frameQ [$];

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_byte_valid (byteValid),
    .i_byte_data  (byteData),
    .o_byte_ready (byteReady),
    .o_wr_en      (wrEn),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .o_cpu_hold   (cpuHold),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (wordCount)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log RAM writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (wrEn) begin
      if (wrCnt < 8) begin
        wrAddrLog[wrCnt] = wrAddr;
        wrDataLog[wrCnt] = wrData;
      end
      wrCnt++;
    end
    if (done) doneCnt++;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse, returns on the negedge after it was sampled
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Send frameQ, idling 'gap' cycles before each byte after the first;
  // returns on the negedge following the last accepting edge
  task automatic applyStimulus(input int gap);
    for (int i = 0; i < frameQ.size(); i++) begin
      bit accepted;
      if (i != 0) repeat (gap) @(negedge clk);
      byteValid = 1'b1;
      byteData  = frameQ[i];
      accepted  = 1'b0;
      for (int w = 0; w < 40 && !accepted; w++) begin
        if (byteReady) accepted = 1'b1;
        @(negedge clk);
      end
      byteValid = 1'b0;
      if (!accepted) begin
        checkOutput("byte accept wait", 64'd0, 64'd1);
        break;
      end
    end
    byteValid = 1'b0;
  endtask

  task automatic clearLog();
    wrCnt   = 0;
    doneCnt = 0;
  endtask

  task automatic checkNormalWrites(input string tag);
    checkOutput({tag, " write count"}, 64'(wrCnt), 64'd2);
    checkOutput({tag, " addr0"}, 64'(wrAddrLog[0]), 64'd0);
    checkOutput({tag, " data0"}, 64'(wrDataLog[0]), 64'h8c100000);
    checkOutput({tag, " addr1"}, 64'(wrAddrLog[1]), 64'd1);
    checkOutput({tag, " data1"}, 64'(wrDataLog[1]), 64'h00102021);
  endtask

  initial begin
    rstN = 1'b1; start = 1'b0; byteValid = 1'b0; byteData = 8'h00;
    #2 rstN = 1'b0;
    #3;
    checkOutput("reset byte_ready", 64'(byteReady), 64'd0);
    checkOutput("reset wr_en", 64'(wrEn), 64'd0);
    checkOutput("reset cpu_hold", 64'(cpuHold), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset error", 64'(error), 64'd0);
    checkOutput("reset wr_addr", 64'(wrAddr), 64'd0);
    checkOutput("reset wr_data", 64'(wrData), 64'd0);
    checkOutput("reset word_count", 64'(wordCount), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Normal load, back-to-back bytes
    $display("[TB] normal load");
    clearLog();
    pulseStart();
    checkOutput("normal cpu_hold after start", 64'(cpuHold), 64'd1);
    checkOutput("normal byte_ready after start", 64'(byteReady), 64'd1);
    frameQ = '{8'h00, 8'h02, 8'h8C, 8'h10, 8'h00, 8'h00,
               8'h00, 8'h10, 8'h20, 8'h21, 8'hED};
    applyStimulus(0);
    checkOutput("normal done", 64'(done), 64'd1);
    checkOutput("normal cpu_hold released", 64'(cpuHold), 64'd0);
    checkOutput("normal error", 64'(error), 64'd0);
    checkOutput("normal word_count", 64'(wordCount), 64'd2);
    checkNormalWrites("normal");
    @(negedge clk);
    checkOutput("normal done one cycle", 64'(done), 64'd0);
    checkOutput("normal word_count hold", 64'(wordCount), 64'd2);
    checkOutput("normal done pulses", 64'(doneCnt), 64'd1);

    // Bad checksum, then a good reload from ERR
    $display("[TB] bad checksum");
    clearLog();
    pulseStart();
    frameQ[10] = 8'hEE;
    applyStimulus(0);
    repeat (2) @(negedge clk);
    checkOutput("badchk error", 64'(error), 64'd1);
    checkOutput("badchk cpu_hold", 64'(cpuHold), 64'd1);
    checkOutput("badchk done pulses", 64'(doneCnt), 64'd0);
    checkNormalWrites("badchk");
    clearLog();
    pulseStart();
    checkOutput("reload error cleared", 64'(error), 64'd0);
    frameQ[10] = 8'hED;
    applyStimulus(0);
    checkOutput("reload done", 64'(done), 64'd1);
    checkNormalWrites("reload");

    // Oversize header: 257 words
    $display("[TB] oversize header");
    @(negedge clk);
    clearLog();
    pulseStart();
    frameQ = '{8'h01, 8'h01};
    applyStimulus(0);
    checkOutput("oversize error", 64'(error), 64'd1);
    checkOutput("oversize byte_ready", 64'(byteReady), 64'd0);
    checkOutput("oversize cpu_hold", 64'(cpuHold), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("oversize no writes", 64'(wrCnt), 64'd0);

    // Empty load from ERR
    $display("[TB] empty load");
    clearLog();
    pulseStart();
    frameQ = '{8'h00, 8'h00, 8'h00};
    applyStimulus(0);
    checkOutput("empty done", 64'(done), 64'd1);
    checkOutput("empty word_count", 64'(wordCount), 64'd0);
    checkOutput("empty no writes", 64'(wrCnt), 64'd0);

    // Gapped stream with byte_valid toggling
    $display("[TB] gapped load");
    @(negedge clk);
    clearLog();
    pulseStart();
    frameQ = '{8'h00, 8'h02, 8'h8C, 8'h10, 8'h00, 8'h00,
               8'h00, 8'h10, 8'h20, 8'h21, 8'hED};
    applyStimulus(1);
    checkOutput("gapped done", 64'(done), 64'd1);
    checkOutput("gapped word_count", 64'(wordCount), 64'd2);
    checkNormalWrites("gapped");

    // Timeout after three payload bytes
    $display("[TB] timeout");
    @(negedge clk);
    clearLog();
    pulseStart();
    frameQ = '{8'h00, 8'h01, 8'h8C, 8'h10, 8'h00};
    applyStimulus(0);
    repeat (15) @(negedge clk);
    checkOutput("timeout not yet at 15", 64'(error), 64'd0);
    @(negedge clk);
    checkOutput("timeout error at 16", 64'(error), 64'd1);
    checkOutput("timeout cpu_hold", 64'(cpuHold), 64'd1);
    checkOutput("timeout no writes", 64'(wrCnt), 64'd0);

    // Reset in the middle of a load
    $display("[TB] reset mid-load");
    pulseStart();
    frameQ = '{8'h00, 8'h02, 8'h8C, 8'h10};
    applyStimulus(0);
    checkOutput("midrst hold before reset", 64'(cpuHold), 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst cpu_hold", 64'(cpuHold), 64'd0);
    checkOutput("midrst byte_ready", 64'(byteReady), 64'd0);
    checkOutput("midrst error", 64'(error), 64'd0);
    checkOutput("midrst word_count", 64'(wordCount), 64'd0);
    checkOutput("midrst wr_data", 64'(wrData), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    clearLog();
    pulseStart();
    frameQ = '{8'h00, 8'h02, 8'h8C, 8'h10, 8'h00, 8'h00,
               8'h00, 8'h10, 8'h20, 8'h21, 8'hED};
    applyStimulus(0);
    checkOutput("postrst done", 64'(done), 64'd1);
    checkNormalWrites("postrst");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU instruction memory, which is a 256-word, word-addressed store indexed by Address[9:2].
- Accepts a framed byte stream over a valid/ready interface: word-count header, big-endian instruction words, checksum.
- Packs the bytes into 32-bit words and writes them through the instruction RAM write port.
- Holds the pipeline CPU in reset (cpu_hold) while a load is in progress.

Parameters:
- ADDR_WIDTH, 8: word-index width; capacity is 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles allowed between accepted bytes during a load.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction RAM write strobe.
- wr_addr  out  ADDR_WIDTH  word index being written.
- wr_data  out  32  instruction word being written.
- cpu_hold  out  1  keeps the CPU in reset while high.
- done  out  1  one-cycle pulse on a successful load.
- error  out  1  sticky error flag; cleared by start or reset.
- word_count  out  ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - byte_ready, wr_en, cpu_hold, done and error are all 0.
  - wr_addr, wr_data, word_count, checksum accumulator and timeout counter are all 0.
- Frame format:
  - Header: N as 16 bits, MSB byte first.
  - Payload: 4*N bytes; each word is sent MSB byte first, so 0x8c100000 arrives as 8C 10 00 00.
  - Trailer: one checksum byte equal to the sum mod 256 of all payload bytes. Header bytes are excluded.
- A byte is accepted when byte_valid && byte_ready. byte_ready is a function of state only: 1 in HDR_HI, HDR_LO, DATA and CHECK, 0 otherwise.
- States:
  - IDLE: start -> HDR_HI. On that transition: cpu_hold=1, error=0, word_count=0, checksum=0, byte lane=0.
  - HDR_HI: accept -> latch N[15:8], go to HDR_LO.
  - HDR_LO: accept -> latch N[7:0].
    - If N > 2^ADDR_WIDTH -> ERR.
    - Else if N == 0 -> CHECK.
    - Else -> DATA.
  - DATA:
    - Each accepted byte shifts into the word register and adds to the checksum.
    - On the 4th byte of a word, the next cycle has wr_en=1 for exactly one cycle, with wr_addr = word_count[ADDR_WIDTH-1:0] and wr_data = the assembled word. word_count increments in that same cycle.
    - Write latency is 1 cycle after the 4th byte is accepted.
    - After the N-th word's write -> CHECK.
    - Bytes may arrive on every cycle; the write does not stall byte_ready.
  - CHECK: accept -> if the byte equals the checksum -> DONE, else -> ERR.
  - DONE:
    - Lasts one cycle: done=1 and cpu_hold drops to 0, then -> IDLE.
    - word_count holds its value until the next start.
  - ERR:
    - error=1 and cpu_hold stays 1, so a corrupted program never runs.
    - start -> HDR_HI (restart). Otherwise the state holds.
    - Words already written are not rolled back.
- Timeout:
  - In HDR_HI, HDR_LO, DATA and CHECK, a counter increments on every cycle without an accept and clears on an accept.
  - Reaching TIMEOUT_CYCLES -> ERR.
- start while in HDR_HI, HDR_LO, DATA, CHECK or DONE is ignored.
- Writes never wrap: the header check guarantees wr_addr < 2^ADDR_WIDTH.
- Reset asserted mid-load forces IDLE asynchronously and releases cpu_hold. The RAM content is then undefined as seen by the CPU, and the system controller must restart the load.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state encodings (IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERR);
  - HDR_BYTES=2, WORD_BYTES=4, CHK_WIDTH=8.
- One sub-module, imem_word_packer:
  - ports: byte-in strobe, 2-bit lane counter, 32-bit shift register, word_complete pulse;
  - the FSM owns the checksum, the counters and the write port.

Test Plan:
- Normal load: start, then bytes 00 02 8C 10 00 00 00 10 20 21 ED, one per cycle -> wr_en at addr 0 with 0x8c100000, wr_en at addr 1 with 0x00102021, done pulse, cpu_hold 1->0, word_count=2, error=0.
- Bad checksum: same frame with last byte EE -> both writes occur, error=1, cpu_hold stays 1, no done. A following start with the correct frame succeeds and clears error.
- Oversize header: 01 01 (257 words, ADDR_WIDTH=8) -> ERR after the second header byte, wr_en never asserted.
- Empty load: 00 00 00 -> done with no writes and word_count=0. Gapped stream with byte_valid toggling every other cycle gives the same writes as the normal load.
- Timeout (TIMEOUT_CYCLES=16): after header 00 01 send 8C 10 00, then hold byte_valid low -> error=1 exactly 16 cycles after the last accept, no write.
- Reset mid-load: assert rst_n=0 after the 2nd payload byte -> all outputs 0 immediately; after release, start plus a full frame loads correctly from addr 0.
